// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word sizes, shifter FSM encoding and shift modes.
package mips_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef logic [1:0] state_t;

    // Encoding 2'b11 is unreachable and is decoded as IDLE by the shifter
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic SHIFT_LOGICAL = 1'b0;
    localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/shift_right_1.sv
// Combinational single-position right shift; fill supplies the new MSB.
module shift_right_1
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    assign dout = {fill, din[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// Iterative SRL/SRA shifter for the EX stage: one bit position per clock,
// busy while occupied, done pulses with the new result.
module shift_right_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_sh;
    logic [SHW-1:0]   cnt;
    logic             mode;
    logic             fill;
    logic             last_step;

    // Sign bit comes from the latched operand, never the live input
    assign fill      = (mode == SHIFT_ARITH) ? shreg[WIDTH-1] : 1'b0;
    assign last_step = (cnt == SHW'(1));

    shift_right_1 #(
        .WIDTH (WIDTH)
    ) u_shift_right_1 (
        .din  (shreg),
        .fill (fill),
        .dout (shreg_sh)
    );

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_SHIFT: state_nxt = last_step ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_nxt = ST_IDLE;
            default: begin
                if (start) begin
                    state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            cnt    <= '0;
            mode   <= SHIFT_LOGICAL;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
            done  <= (state_nxt == ST_DONE);
            case (state)
                ST_SHIFT: begin
                    shreg <= shreg_sh;
                    cnt   <= cnt - SHW'(1);
                    // Final step: capture the fully shifted word as DONE is entered
                    if (last_step) begin
                        result <= shreg_sh;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    if (start) begin
                        shreg <= data_in;
                        cnt   <= shamt;
                        mode  <= arith;
                        if (shamt == '0) begin
                            result <= data_in;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases plus random operations
// compared against a plain-arithmetic shift model with cycle-exact busy/done timing.
module tb_shift_right_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        arith;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int          checks;
    int          failures;
    logic [31:0] prev_result;

    shift_right_seq #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .arith   (arith),
        .data_in (data_in),
        .shamt   (shamt),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        if (a) return $signed(d) >>> s;
        return d >> s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in an idle cycle (cycle 0); returns at the negedge of
    // cycle s+2, which is idle again and may host the next start.
    task automatic run_op(input logic [31:0] d, input int s, input logic a, input int extra);
        logic [31:0] exp;
        exp     = ref_shift(d, 5'(s), a);
        start   = 1'b1;
        data_in = d;
        shamt   = 5'(s);
        arith   = a;
        for (int c = 1; c <= s + 1; c++) begin
            @(negedge clk);
            start   = (c == extra);
            data_in = (c == extra) ? 32'h12345678 : $urandom;
            shamt   = 5'($urandom);
            arith   = 1'($urandom);
            chk("busy_active", 32'(busy), 32'd1);
            chk("done_timing", 32'(done), 32'(c == s + 1));
            chk("result", result, (c == s + 1) ? exp : prev_result);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
        chk("result_held", result, exp);
        prev_result = exp;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        prev_result = 32'h0;
        reset       = 1'b1;
        start       = 1'b0;
        arith       = 1'b0;
        data_in     = 32'h0;
        shamt       = 5'd0;

        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'hFFFFFFFF, 4, 1'b0, 0);
        chk("srl_ffffffff_4", result, 32'h0FFFFFFF);
        run_op(32'h80000000, 31, 1'b1, 0);
        chk("sra_80000000_31", result, 32'hFFFFFFFF);
        run_op(32'h80000000, 31, 1'b0, 0);
        chk("srl_80000000_31", result, 32'h00000001);
        run_op(32'hFFFF7FFF, 0, 1'b1, 0);
        chk("sra_shamt0", result, 32'hFFFF7FFF);
        run_op(32'hF0000000, 8, 1'b0, 3);
        chk("start_while_busy", result, 32'h00F00000);
        run_op(32'hFFFFBFFF, 2, 1'b0, 0);
        chk("srl_ffffbfff_2", result, 32'h3FFFEFFF);
        run_op(32'hFFFFBFFF, 2, 1'b1, 0);
        chk("sra_ffffbfff_2", result, 32'hFFFFEFFF);
        run_op(32'h0000A5A5, 3, 1'b1, 4);
        chk("start_during_done", result, 32'h000014B4);

        // Abort a long SRA with reset in cycle 4
        start   = 1'b1;
        data_in = 32'h80000000;
        shamt   = 5'd20;
        arith   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = $urandom;
            chk("abort_busy", 32'(busy), 32'd1);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_result", result, prev_result);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy_cleared", 32'(busy), 32'd0);
        chk("abort_done_cleared", 32'(done), 32'd0);
        chk("abort_result_cleared", result, 32'h0);
        prev_result = 32'h0;
        run_op(32'h000000F0, 4, 1'b0, 0);
        chk("srl_after_reset", result, 32'h0000000F);

        for (int i = 0; i < 25; i++) begin
            int s;
            s = int'($urandom_range(0, 31));
            run_op($urandom, s, 1'($urandom), int'($urandom_range(0, s + 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
